fft16_bf_sched: RTL and testbench
=================================

FFT16_BF_SCHED -- requirements
Module: fft16_bf_sched

Interface
REQ-001 Parameter: BF_LAT, default 4, pipeline latency in cycles of the shared butterfly datapath (compmult + compadder pair); legal range 1..8.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, as the first two ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-003 The block SHALL have the following remaining ports:
- start  in  1  single-cycle request to run one 16-point FFT
- abort  in  1  synchronous cancel of the current run
- busy  out  1  high from the first issue cycle to the final write cycle
- done  out  1  one-cycle pulse after the final write of stage 3
- bf_valid  out  1  a butterfly is issued this cycle
- rd_addr_a  out  4  sample-RAM index of butterfly top input
- rd_addr_b  out  4  sample-RAM index of butterfly bottom input
- tw_idx  out  3  twiddle index k selecting W16^k, k = 0..7
- wr_en  out  1  write both butterfly results this cycle
- wr_addr_a  out  4  index for top result (sum)
- wr_addr_b  out  4  index for bottom result (difference)
- stage  out  2  current stage number 0..3

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, DRAIN and FIN; the reset state is IDLE.
REQ-005 IDLE: start=1 SHALL move the FSM to ISSUE with stage=0 and butterfly counter k=0; start is ignored in every other state.
REQ-006 ISSUE: the block SHALL assert bf_valid for exactly 8 consecutive cycles, k=0..7; after k=7 it SHALL enter DRAIN.
REQ-007 Addressing SHALL be radix-2 DIT on bit-reversed input:
- span = 2^stage
- pos = k mod span
- grp = k div span
- rd_addr_a = 2*span*grp + pos
- rd_addr_b = rd_addr_a + span
- tw_idx = pos * 2^(3-stage)
REQ-008 The write path SHALL reproduce the read path exactly BF_LAT cycles later: wr_en, wr_addr_a and wr_addr_b equal bf_valid, rd_addr_a and rd_addr_b delayed by BF_LAT cycles.
REQ-009 DRAIN SHALL last exactly BF_LAT cycles, so the next stage never reads data that has not yet been written.
REQ-010 At the end of DRAIN the FSM SHALL go to ISSUE with stage+1 if stage<3; otherwise it SHALL go to FIN.
REQ-011 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-012 Timing, with start sampled at cycle 0:
- the issue of (stage s, k) occurs at cycle 1 + s*(8+BF_LAT) + k
- its write occurs BF_LAT cycles later
- done occurs at cycle 1 + 4*(8+BF_LAT); this is cycle 49 for BF_LAT=4
REQ-013 busy SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE and FIN.
REQ-014 The stage output SHALL hold its value through DRAIN and SHALL read 0 in IDLE.
REQ-015 When an output is not qualified by its valid signal, the address outputs and tw_idx SHALL be driven to 0.
REQ-016 abort=1 in any state other than IDLE SHALL, on the next edge:
- return the FSM to IDLE
- clear the delay line, so wr_en=0 from the next cycle on
- suppress done
REQ-017 Simultaneous start and abort in IDLE: abort SHALL win, and the FSM SHALL stay in IDLE.

Reset
REQ-018 While rst_n=0 the block SHALL force, asynchronously:
- the FSM to IDLE
- stage and k to 0
- all delay-line valid bits to 0
- every output to 0
REQ-019 Deassertion of rst_n during a run SHALL NOT resume that run; a new start is required.

Structure
REQ-020 A shared package fft_pkg SHALL hold:
- FFT_N=16, FFT_LOG2N=4, CPLX_W=64, TW_W=3
- the state enum type
REQ-021 The write path SHALL be a single sub-module fft_delay_line, BF_LAT stages deep and 9 bits wide ({valid, addr_a, addr_b}), with asynchronous reset and a synchronous clear.
REQ-022 The block SHALL contain no arithmetic datapath; it only sequences the external butterfly unit and the sample RAM.

Verification
REQ-023 Full run, BF_LAT=4, start pulse at cycle 0: 32 bf_valid pulses; done at cycle 49 only; busy high for cycles 1..48.
REQ-024 Address check for stage 2, k=5 (span=4, grp=1, pos=1): rd_a=9, rd_b=13, tw_idx=2; the write to addresses 9/13 follows 4 cycles later.
REQ-025 Stage 3: rd_a=k, rd_b=k+8, tw_idx=k for k=0..7; stage 0: rd_a=2k, rd_b=2k+1, tw_idx=0.
REQ-026 Hazard check: the first stage-1 read occurs one cycle after the last stage-0 write (cycle 13 vs 12 for BF_LAT=4).
REQ-027 abort at cycle 20: wr_en=0, busy=0 and done=0 from cycle 21 on; a following start produces a clean full run.
REQ-028 rst_n pulsed low at cycle 30: all outputs go 0 immediately; a start pulse while busy is ignored; BF_LAT=1 gives done at cycle 37.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants, FSM state type and butterfly address helpers for the
// 16-point radix-2 DIT butterfly scheduler.
//
// Contents:
//   FFT_N, FFT_LOG2N      transform size and number of stages
//   CPLX_W                width of one complex sample in the sample RAM
//   TW_W                  width of the twiddle index (k of W16^k, k = 0..7)
//   BF_PER_STAGE          butterflies issued per stage
//   state_t               scheduler FSM states
//   bf_span/bf_addr_a/bf_tw  per-(stage, k) address and twiddle generation
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N        = 16;
  localparam int FFT_LOG2N    = 4;
  localparam int CPLX_W       = 64;
  localparam int TW_W         = 3;
  localparam int BF_PER_STAGE = FFT_N / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Distance between the two inputs of a butterfly in stage stg (2^stg).
  function automatic logic [3:0] bf_span(input logic [1:0] stg);
    return 4'd1 << stg;
  endfunction

  // Top input index: 2*span*grp + pos with grp = k div span, pos = k mod span.
  // Since span is a power of two, the multiply and divide reduce to shifts
  // and the add to an OR (pos never overlaps the shifted group bits).
  function automatic logic [3:0] bf_addr_a(input logic [1:0] stg,
                                           input logic [2:0] k);
    logic [3:0] kk;
    logic [3:0] pos;
    logic [3:0] grp;
    kk  = {1'b0, k};
    pos = kk & (bf_span(stg) - 4'd1);
    grp = kk >> stg;
    return (grp << ({1'b0, stg} + 3'd1)) | pos;
  endfunction

  // Twiddle index pos * 2^(3-stg); stays within 0..7 for every stage.
  function automatic logic [TW_W-1:0] bf_tw(input logic [1:0] stg,
                                            input logic [2:0] k);
    logic [2:0] pos;
    pos = k & 3'(bf_span(stg) - 4'd1);
    return pos << (2'd3 - stg);
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// -----------------------------------------------------------------------------
// fft_delay_line
// Fixed-depth shift register that replays the read-side butterfly descriptor
// ({valid, addr_a, addr_b}) as the write-side descriptor DEPTH cycles later,
// matching the latency of the external butterfly datapath.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, empties every stage
//   clear  in   synchronous clear, empties every stage on the next edge
//   din    in   descriptor entering the line this cycle
//   dout   out  descriptor that entered DEPTH cycles ago
// -----------------------------------------------------------------------------
module fft_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (clear) begin
      // Clearing also drops the descriptor presented this cycle, so a
      // cancelled run can never produce a late write.
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft16_bf_sched.sv
// -----------------------------------------------------------------------------
// fft16_bf_sched
// Address/control sequencer for an in-place 16-point radix-2 DIT FFT over a
// bit-reversed sample RAM, sharing one pipelined butterfly unit. It contains
// no arithmetic datapath: it issues 8 butterflies per stage, waits BF_LAT
// cycles for the last results to land, and moves on through 4 stages.
//
// Parameter:
//   BF_LAT     latency of the butterfly datapath in cycles, legal 1..8
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request to run an FFT (honoured in IDLE only)
//   abort      in   synchronous cancel of the current run
//   busy       out  high in ISSUE and DRAIN
//   done       out  one-cycle pulse (FIN) after the last stage-3 write
//   bf_valid   out  a butterfly is issued this cycle
//   rd_addr_a  out  RAM index of butterfly top input
//   rd_addr_b  out  RAM index of butterfly bottom input
//   tw_idx     out  twiddle index k of W16^k
//   wr_en      out  write both butterfly results this cycle
//   wr_addr_a  out  RAM index for top result (sum)
//   wr_addr_b  out  RAM index for bottom result (difference)
//   stage      out  current stage 0..3, 0 in IDLE
//
// Handshake: bf_valid and wr_en are pure valid qualifiers with no ready; the
// butterfly unit and RAM must accept every qualified cycle. Address and
// twiddle outputs read 0 whenever their qualifier is low.
// -----------------------------------------------------------------------------
module fft16_bf_sched
  import fft_pkg::*;
#(
  parameter int BF_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       bf_valid,
  output logic [3:0] rd_addr_a,
  output logic [3:0] rd_addr_b,
  output logic [2:0] tw_idx,
  output logic       wr_en,
  output logic [3:0] wr_addr_a,
  output logic [3:0] wr_addr_b,
  output logic [1:0] stage
);

  localparam logic [2:0] K_LAST     = 3'(BF_PER_STAGE - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT - 1);
  localparam logic [1:0] STAGE_LAST = 2'(FFT_LOG2N - 1);

  state_t     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [2:0] k_q, k_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dl_clear;
  logic [8:0] dl_in;
  logic [8:0] dl_out;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= 2'd0;
      k_q     <= 3'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    dl_clear = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    bf_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          stage_d = 2'd0;
          k_d     = 3'd0;
        end
      end

      ISSUE: begin
        busy     = 1'b1;
        bf_valid = 1'b1;
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = 3'd0;
          cnt_d   = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      // Hold off the next stage until the last butterfly of this stage has
      // been written back; with exactly BF_LAT drain cycles the next stage's
      // first read lands one cycle after that write.
      DRAIN: begin
        busy = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d = 3'd0;
          if (stage_q == STAGE_LAST) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
        stage_d = 2'd0;
      end

      default: begin
        state_d = IDLE;
        stage_d = 2'd0;
      end
    endcase

    // Abort overrides every transition above and flushes in-flight writes.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      stage_d  = 2'd0;
      k_d      = 3'd0;
      cnt_d    = 3'd0;
      dl_clear = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-side addressing, forced to 0 when no butterfly is issued
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_addr_a = 4'd0;
    rd_addr_b = 4'd0;
    tw_idx    = 3'd0;
    if (bf_valid) begin
      rd_addr_a = bf_addr_a(stage_q, k_q);
      rd_addr_b = bf_addr_a(stage_q, k_q) + bf_span(stage_q);
      tw_idx    = bf_tw(stage_q, k_q);
    end
  end

  assign stage = stage_q;

  // ---------------------------------------------------------------------------
  // Write side: the read descriptor replayed BF_LAT cycles later
  // ---------------------------------------------------------------------------
  assign dl_in = {bf_valid, rd_addr_a, rd_addr_b};

  fft_delay_line #(
    .DEPTH (BF_LAT),
    .WIDTH (9)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (dl_clear),
    .din   (dl_in),
    .dout  (dl_out)
  );

  always_comb begin
    wr_en     = dl_out[8];
    wr_addr_a = 4'd0;
    wr_addr_b = 4'd0;
    if (dl_out[8]) begin
      wr_addr_a = dl_out[7:4];
      wr_addr_b = dl_out[3:0];
    end
  end

endmodule

// File: tb/tb_fft16_bf_sched.sv
// -----------------------------------------------------------------------------
// tb_fft16_bf_sched
// Bench for fft16_bf_sched. Main instance uses BF_LAT=4 with a scoreboard of
// expected issue/write descriptors (tagged with their cycle); a second
// instance with BF_LAT=1 checks the short-latency timing.
// -----------------------------------------------------------------------------
module tb_fft16_bf_sched;

  localparam int LAT  = 4;
  localparam int LAT1 = 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic       start, abort;
  logic       busy, done, bf_valid, wr_en;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_idx;
  logic [1:0] stage;

  logic       start1, abort1;
  logic       busy1, done1, bf_valid1, wr_en1;
  logic [3:0] rd_addr_a1, rd_addr_b1, wr_addr_a1, wr_addr_b1;
  logic [2:0] tw_idx1;
  logic [1:0] stage1;

  fft16_bf_sched #(.BF_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .bf_valid(bf_valid),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .stage(stage)
  );

  fft16_bf_sched #(.BF_LAT(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .bf_valid(bf_valid1),
    .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1), .tw_idx(tw_idx1),
    .wr_en(wr_en1), .wr_addr_a(wr_addr_a1), .wr_addr_b(wr_addr_b1),
    .stage(stage1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: {cycle[15:0], stage, rd_a, rd_b, tw} and {cycle, wr_a, wr_b}
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  logic [28:0] exp_rd_q[$];
  logic [23:0] exp_wr_q[$];
  logic [28:0] exp_rd, got_rd;
  logic [23:0] exp_wr, got_wr;

  // Reference model of one full run whose start is high during cycle t0.
  task automatic push_run(input int t0);
    int span, pos, grp, a, b, tw, ic;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        span = 1 << s;
        pos  = k % span;
        grp  = k / span;
        a    = 2 * span * grp + pos;
        b    = a + span;
        tw   = pos * (8 / span);
        ic   = t0 + 1 + s * (8 + LAT) + k;
        exp_rd_q.push_back({16'(ic), 2'(s), 4'(a), 4'(b), 3'(tw)});
        exp_wr_q.push_back({16'(ic + LAT), 4'(a), 4'(b)});
      end
    end
  endtask

  always @(negedge clk) begin
    if (bf_valid) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected cyc=%0d got a=%0d b=%0d required no issue",
                 cyc, rd_addr_a, rd_addr_b);
      end else begin
        exp_rd = exp_rd_q.pop_front();
        got_rd = {16'(cyc), stage, rd_addr_a, rd_addr_b, tw_idx};
        if (got_rd !== exp_rd) begin
          failures++;
          $display("FAIL rd_issue got cyc/stg/a/b/tw=%0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
                   got_rd[28:13], got_rd[12:11], got_rd[10:7], got_rd[6:3], got_rd[2:0],
                   exp_rd[28:13], exp_rd[12:11], exp_rd[10:7], exp_rd[6:3], exp_rd[2:0]);
        end
      end
    end else begin
      checks++;
      if ({rd_addr_a, rd_addr_b, tw_idx} !== 11'd0) begin
        failures++;
        $display("FAIL rd_idle_zero cyc=%0d got a=%0d b=%0d tw=%0d required 0",
                 cyc, rd_addr_a, rd_addr_b, tw_idx);
      end
    end

    if (wr_en) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected cyc=%0d got a=%0d b=%0d required no write",
                 cyc, wr_addr_a, wr_addr_b);
      end else begin
        exp_wr = exp_wr_q.pop_front();
        got_wr = {16'(cyc), wr_addr_a, wr_addr_b};
        if (got_wr !== exp_wr) begin
          failures++;
          $display("FAIL wr_write got cyc/a/b=%0d/%0d/%0d required %0d/%0d/%0d",
                   got_wr[23:8], got_wr[7:4], got_wr[3:0],
                   exp_wr[23:8], exp_wr[7:4], exp_wr[3:0]);
        end
      end
    end else begin
      checks++;
      if ({wr_addr_a, wr_addr_b} !== 8'd0) begin
        failures++;
        $display("FAIL wr_idle_zero cyc=%0d got a=%0d b=%0d required 0",
                 cyc, wr_addr_a, wr_addr_b);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bf_valid, rd_addr_a, rd_addr_b, tw_idx, wr_en,
         wr_addr_a, wr_addr_b, stage} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b done=%0b valid=%0b stage=%0d required all 0",
               busy, done, bf_valid, stage);
    end
    checks++;
    if ({busy1, done1, bf_valid1, rd_addr_a1, rd_addr_b1, tw_idx1, wr_en1,
         wr_addr_a1, wr_addr_b1, stage1} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs_lat1 got busy=%0b done=%0b valid=%0b required all 0",
               busy1, done1, bf_valid1);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, stage} !== 4'd0) begin
        failures++;
        $display("FAIL idle_after_reset got busy=%0b done=%0b stage=%0d required 0",
                 busy, done, stage);
      end
    end
  endtask

  task automatic test_full_run();
    int t0, pulses;
    @(negedge clk);
    t0 = cyc;
    push_run(t0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int rel = 1; rel <= 52; rel++) begin
      // Extra start pulses mid-run (in DRAIN and in ISSUE) must be ignored.
      start = (rel == 10 || rel == 40);
      if (bf_valid) pulses++;
      checks++;
      if (busy !== (rel <= 48)) begin
        failures++;
        $display("FAIL busy rel=%0d got=%0b required=%0b", rel, busy, (rel <= 48));
      end
      checks++;
      if (done !== (rel == 49)) begin
        failures++;
        $display("FAIL done rel=%0d got=%0b required=%0b", rel, done, (rel == 49));
      end
      if (rel <= 48 || rel >= 50) begin
        checks++;
        if (stage !== ((rel <= 48) ? 2'((rel - 1) / 12) : 2'd0)) begin
          failures++;
          $display("FAIL stage rel=%0d got=%0d", rel, stage);
        end
      end
      if (rel == 12) begin
        checks++;
        if (!(wr_en === 1'b1 && wr_addr_a === 4'd14 && wr_addr_b === 4'd15)) begin
          failures++;
          $display("FAIL last_stage0_write got en=%0b a=%0d b=%0d required 1/14/15",
                   wr_en, wr_addr_a, wr_addr_b);
        end
      end
      if (rel == 13) begin
        checks++;
        if (!(bf_valid === 1'b1 && stage === 2'd1 && wr_en === 1'b0)) begin
          failures++;
          $display("FAIL first_stage1_read got valid=%0b stage=%0d wr_en=%0b required 1/1/0",
                   bf_valid, stage, wr_en);
        end
      end
      if (rel == 30) begin
        checks++;
        if (!(rd_addr_a === 4'd9 && rd_addr_b === 4'd13 && tw_idx === 3'd2)) begin
          failures++;
          $display("FAIL s2k5_read got a=%0d b=%0d tw=%0d required 9/13/2",
                   rd_addr_a, rd_addr_b, tw_idx);
        end
      end
      if (rel == 34) begin
        checks++;
        if (!(wr_en === 1'b1 && wr_addr_a === 4'd9 && wr_addr_b === 4'd13)) begin
          failures++;
          $display("FAIL s2k5_write got en=%0b a=%0d b=%0d required 1/9/13",
                   wr_en, wr_addr_a, wr_addr_b);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (pulses != 32) begin
      failures++;
      $display("FAIL pulse_count got=%0d required=32", pulses);
    end
    checks++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      failures++;
      $display("FAIL run_complete got pending rd=%0d wr=%0d required 0/0",
               exp_rd_q.size(), exp_wr_q.size());
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic test_abort(input int abort_rel);
    int t0, rem_rd, rem_wr, ic;
    @(negedge clk);
    t0 = cyc;
    push_run(t0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rem_rd = 0;
    rem_wr = 0;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        ic = 1 + s * (8 + LAT) + k;
        if (ic > abort_rel) rem_rd++;
        if (ic + LAT > abort_rel) rem_wr++;
      end
    end
    for (int rel = 1; rel <= abort_rel + 6; rel++) begin
      abort = (rel == abort_rel);
      if (rel <= abort_rel) begin
        checks++;
        if (busy !== (rel <= 48)) begin
          failures++;
          $display("FAIL abort_busy_before rel=%0d got=%0b", rel, busy);
        end
      end else begin
        checks++;
        if ({busy, done, wr_en, bf_valid} !== 4'b0000) begin
          failures++;
          $display("FAIL abort_quiet rel=%0d got busy=%0b done=%0b wr_en=%0b valid=%0b required 0",
                   rel, busy, done, wr_en, bf_valid);
        end
      end
      if (rel == abort_rel + 1) begin
        checks++;
        if (exp_rd_q.size() != rem_rd || exp_wr_q.size() != rem_wr) begin
          failures++;
          $display("FAIL abort_remaining got rd=%0d wr=%0d required %0d/%0d",
                   exp_rd_q.size(), exp_wr_q.size(), rem_rd, rem_wr);
        end
        exp_rd_q.delete();
        exp_wr_q.delete();
      end
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({busy, bf_valid, done, stage} !== 5'd0) begin
        failures++;
        $display("FAIL start_abort_idle i=%0d got busy=%0b valid=%0b done=%0b stage=%0d required 0",
                 i, busy, bf_valid, done, stage);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic exp_busy;
    @(negedge clk);
    t0 = cyc;
    push_run(t0);
    push_run(t0 + 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int rel = 1; rel <= 101; rel++) begin
      // High in FIN (ignored) and again in IDLE (accepted).
      start = (rel == 49 || rel == 50);
      exp_busy = (rel <= 48) || (rel >= 51 && rel <= 98);
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL b2b_busy rel=%0d got=%0b required=%0b", rel, busy, exp_busy);
      end
      checks++;
      if (done !== (rel == 49 || rel == 99)) begin
        failures++;
        $display("FAIL b2b_done rel=%0d got=%0b required=%0b", rel, done,
                 (rel == 49 || rel == 99));
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_complete got pending rd=%0d wr=%0d required 0/0",
               exp_rd_q.size(), exp_wr_q.size());
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int t0;
    @(negedge clk);
    t0 = cyc;
    push_run(t0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int rel = 1; rel < 30; rel++) @(negedge clk);
    // Now in cycle 30 (stage 2 issuing); reset asynchronously mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bf_valid, rd_addr_a, rd_addr_b, tw_idx, wr_en,
         wr_addr_a, wr_addr_b, stage} !== 25'd0) begin
      failures++;
      $display("FAIL async_reset got busy=%0b valid=%0b wr_en=%0b stage=%0d required all 0",
               busy, bf_valid, wr_en, stage);
    end
    checks++;
    if (exp_rd_q.size() != 10 || exp_wr_q.size() != 14) begin
      failures++;
      $display("FAIL reset_remaining got rd=%0d wr=%0d required 10/14",
               exp_rd_q.size(), exp_wr_q.size());
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, bf_valid, wr_en, done} !== 4'd0) begin
        failures++;
        $display("FAIL no_resume i=%0d got busy=%0b valid=%0b wr_en=%0b done=%0b required 0",
                 i, busy, bf_valid, wr_en, done);
      end
    end
  endtask

  task automatic test_lat1();
    int pulses;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    pulses = 0;
    for (int rel = 1; rel <= 40; rel++) begin
      if (bf_valid1) pulses++;
      checks++;
      if (busy1 !== (rel <= 36)) begin
        failures++;
        $display("FAIL lat1_busy rel=%0d got=%0b required=%0b", rel, busy1, (rel <= 36));
      end
      checks++;
      if (done1 !== (rel == 37)) begin
        failures++;
        $display("FAIL lat1_done rel=%0d got=%0b required=%0b", rel, done1, (rel == 37));
      end
      if (rel == 9) begin
        checks++;
        if (!(wr_en1 === 1'b1 && wr_addr_a1 === 4'd14 && wr_addr_b1 === 4'd15)) begin
          failures++;
          $display("FAIL lat1_last_s0_write got en=%0b a=%0d b=%0d required 1/14/15",
                   wr_en1, wr_addr_a1, wr_addr_b1);
        end
      end
      if (rel == 10) begin
        checks++;
        if (!(bf_valid1 === 1'b1 && stage1 === 2'd1 && rd_addr_a1 === 4'd0 &&
              rd_addr_b1 === 4'd2 && wr_en1 === 1'b0)) begin
          failures++;
          $display("FAIL lat1_first_s1_read got valid=%0b stage=%0d a=%0d b=%0d wr_en=%0b required 1/1/0/2/0",
                   bf_valid1, stage1, rd_addr_a1, rd_addr_b1, wr_en1);
        end
      end
      if (rel == 31) begin
        checks++;
        if (!(stage1 === 2'd3 && rd_addr_a1 === 4'd3 && rd_addr_b1 === 4'd11 &&
              tw_idx1 === 3'd3)) begin
          failures++;
          $display("FAIL lat1_s3k3_read got stage=%0d a=%0d b=%0d tw=%0d required 3/3/11/3",
                   stage1, rd_addr_a1, rd_addr_b1, tw_idx1);
        end
      end
      if (rel == 32) begin
        checks++;
        if (!(wr_en1 === 1'b1 && wr_addr_a1 === 4'd3 && wr_addr_b1 === 4'd11)) begin
          failures++;
          $display("FAIL lat1_s3k3_write got en=%0b a=%0d b=%0d required 1/3/11",
                   wr_en1, wr_addr_a1, wr_addr_b1);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 32) begin
      failures++;
      $display("FAIL lat1_pulse_count got=%0d required=32", pulses);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_full_run();
    test_abort(20);
    test_full_run();
    test_abort(48);
    test_start_abort_idle();
    test_back_to_back();
    test_reset_mid_run();
    test_full_run();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
